mlu_result_fifo: RTL and testbench
==================================

Name: mlu_result_fifo

Overview:
- Downstream stage of the MLU top: watches the MLU `ready`/`result` pair and captures each new 6-bit result on the rising edge of `ready`.
- Buffers captured results in a small FIFO and presents them to the consumer (display/UART/host logic) over a valid/ready handshake.
- Reports occupancy and a sticky overflow flag.

Parameters:
- DATA_W, 6, result width; matches the MLU `result` port.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mlu_ready  in  1  MLU done/ready level.
- mlu_result  in  DATA_W  MLU result; valid while mlu_ready=1.
- clear  in  1  synchronous flush; empties FIFO and clears overflow.
- out_valid  out  1  FIFO non-empty; out_data holds the head entry.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  DATA_W  head-of-FIFO result (first-word fall-through).
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when a capture is dropped because the FIFO is full.

Behaviour:
- Reset (reset=0, async):
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0, overflow=0.
  - out_data=0; the head output is forced to 0 while empty.
  - ready_d=1, so a `mlu_ready` level held high across reset release is NOT captured.
  - Memory contents are don't-care.
- Edge detect:
  - ready_d <= mlu_ready every cycle.
  - capture = mlu_ready & ~ready_d; this is a one-cycle strobe.
  - mlu_result is sampled in the same cycle as the strobe.
- Push (capture=1, clear=0):
  - If not full, or a pop occurs in the same cycle: mem[wr_ptr] <= mlu_result; wr_ptr++ (mod DEPTH).
  - If full with no pop: the data is dropped; overflow <= 1. Pointers and count are unchanged.
- Pop (out_valid & out_ready, clear=0): rd_ptr++ (mod DEPTH).
- Pop while empty: out_valid=0, so no pop occurs; no underflow state exists.
- Count:
  - +1 on push only, −1 on pop only.
  - Unchanged on simultaneous push+pop, including when full (no overflow set in that case) and when count=1.
- Latency: the capture strobe in cycle T gives out_valid=1 and out_data=result in cycle T+1, when the FIFO was empty.
- out_data:
  - Combinational read of mem[rd_ptr] (FWFT).
  - Must be stable while out_valid=1 and out_ready=0.
  - Ordering is strictly FIFO.
- Pointer wrap:
  - Pointers wrap DEPTH-1 → 0.
  - full = (count==DEPTH); empty = (count==0). Count is explicit, so there is no pointer-extra-bit ambiguity.
- clear=1 (synchronous, highest priority):
  - Pointers and count go to 0; overflow goes to 0.
  - A capture or pop in the same cycle is ignored.
  - ready_d still updates normally.
- Overflow: once set, stays 1 until clear or reset, regardless of later pops.
- Reset mid-operation: all contents are lost. An in-progress `mlu_ready` high level after release produces no capture until `mlu_ready` goes low and then high again.
- mlu_ready held high for many cycles yields exactly one capture.

Test Plan:
- Basic capture:
  - Stimulus: reset low 5 cycles, release; MLU computes A=5,B=5 → result=6'd25, `mlu_ready` rises at cycle T.
  - Required: out_valid=1 and out_data=25 at T+1; count=1. Then out_ready=1 for one cycle → out_valid=0, count=0.
- Level vs edge:
  - Stimulus: `mlu_ready` held high 20 cycles.
  - Required: exactly one entry, count=1.
  - Stimulus: `mlu_ready` high before and through reset release.
  - Required: count=0 until a fresh 0→1 edge.
- Fill and overflow:
  - Stimulus: with out_ready=0, push 25, 10, 63, 0.
  - Required: count=4, overflow=0.
  - Stimulus: fifth push of 7.
  - Required: count=4, overflow=1; pops return 25, 10, 63, 0 in order; overflow stays 1.
- Full with simultaneous push+pop:
  - Stimulus: FIFO full {1,2,3,4}; push 5 with out_ready=1 in the same cycle.
  - Required: count stays 4, overflow=0; drain order is 2, 3, 4, 5.
- Wrap and backpressure:
  - Stimulus: 10 pushes interleaved with pops, values 1..10, out_ready toggling.
  - Required: out_data is stable while stalled; the sequence out is exactly 1..10 across pointer wrap.
- Clear priority:
  - Stimulus: count=3, overflow=1; assert clear in the same cycle as a capture of 42 and out_ready=1.
  - Required: next cycle count=0, out_valid=0, overflow=0; 42 is not stored.

Source files
------------

// File: rtl/mlu_result_fifo_if.sv
// Handshake bundle between the MLU result capture FIFO and its producer/consumer.
// The slave modport is the FIFO side; master is the environment driving it.
interface mlu_result_fifo_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
);
  logic              mlu_ready;
  logic [DATA_W-1:0] mlu_result;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport slave (
    input  mlu_ready, mlu_result, clear, out_ready,
    output out_valid, out_data, count, overflow
  );

  modport master (
    output mlu_ready, mlu_result, clear, out_ready,
    input  out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/mlu_result_fifo.sv
// Captures each MLU result on the rising edge of mlu_ready into a FWFT FIFO.
// Latency: capture strobe in cycle T is visible at the head in T+1; full FIFO drops new data (sticky overflow).
module mlu_result_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  mlu_result_fifo_if.slave bus
);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              ovf_q,    ovf_d;

  logic capture, empty, full, pop, push, drop;

  // ready_q resets high so a level already asserted at reset release is not an edge
  assign capture = bus.mlu_ready & ~ready_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = ~empty & bus.out_ready;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ready_q  <= bus.mlu_ready;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; stale entries are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (push && !bus.clear) mem[wr_ptr_q] <= bus.mlu_result;
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mlu_result_fifo.sv
// Randomised and directed bench for mlu_result_fifo with a queue-based reference model and scoreboard.
module tb_mlu_result_fifo;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk;
  logic reset;

  mlu_result_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mlu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the expected FIFO contents as a plain queue.
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ovf;
  logic              prev_ready;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_ovf    = 1'b0;
      prev_ready = 1'b1;
    end else begin
      logic cap;
      cap        = bus.mlu_ready && !prev_ready;
      prev_ready = bus.mlu_ready;
      if (bus.clear) begin
        exp_q.delete();
        exp_ovf = 1'b0;
      end else begin
        if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
        if (cap) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(bus.mlu_result);
          else exp_ovf = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("mon_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
      check("mon_count", int'(bus.count), exp_q.size());
      check("mon_overflow", int'(bus.overflow), int'(exp_ovf));
      if (exp_q.size() != 0) check("mon_head", int'(bus.out_data), int'(exp_q[0]));
      else check("mon_empty_data", int'(bus.out_data), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DATA_W-1:0] v);
    bus.mlu_result = v;
    bus.mlu_ready  = 1'b1;
    step();
    bus.mlu_ready  = 1'b0;
    step();
  endtask

  initial begin
    logic [DATA_W-1:0] seq [4];

    reset          = 1'b0;
    bus.mlu_ready  = 1'b0;
    bus.mlu_result = '0;
    bus.clear      = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (5) step();
    check("rst_count", int'(bus.count), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    reset = 1'b1;
    step();

    // Basic capture: visible one cycle after the strobe
    bus.mlu_result = 6'd25;
    bus.mlu_ready  = 1'b1;
    step();
    check("basic_valid", int'(bus.out_valid), 1);
    check("basic_data", int'(bus.out_data), 25);
    check("basic_count", int'(bus.count), 1);
    bus.mlu_ready = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("basic_pop_valid", int'(bus.out_valid), 0);
    check("basic_pop_count", int'(bus.count), 0);

    // Long level yields a single capture
    bus.mlu_result = 6'd9;
    bus.mlu_ready  = 1'b1;
    repeat (20) step();
    check("level_count", int'(bus.count), 1);
    bus.mlu_ready = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();

    // Level held through reset release is not an edge
    bus.mlu_ready = 1'b1;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();
    check("rst_level_count", int'(bus.count), 0);
    bus.mlu_ready = 1'b0;
    step();
    bus.mlu_result = 6'd17;
    bus.mlu_ready  = 1'b1;
    step();
    check("fresh_edge_count", int'(bus.count), 1);
    bus.mlu_ready = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Fill and overflow
    seq[0] = 6'd25; seq[1] = 6'd10; seq[2] = 6'd63; seq[3] = 6'd0;
    for (int i = 0; i < 4; i++) pulse(seq[i]);
    check("fill_count", int'(bus.count), 4);
    check("fill_overflow", int'(bus.overflow), 0);
    pulse(6'd7);
    check("ovf_count", int'(bus.count), 4);
    check("ovf_flag", int'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_data", int'(bus.out_data), int'(seq[i]));
      step();
    end
    bus.out_ready = 1'b0;
    check("ovf_drained_count", int'(bus.count), 0);
    check("ovf_sticky", int'(bus.overflow), 1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check("clear_ovf", int'(bus.overflow), 0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) pulse(DATA_W'(i));
    bus.mlu_result = 6'd5;
    bus.mlu_ready  = 1'b1;
    bus.out_ready  = 1'b1;
    step();
    bus.mlu_ready = 1'b0;
    bus.out_ready = 1'b0;
    check("fullpp_count", int'(bus.count), 4);
    check("fullpp_overflow", int'(bus.overflow), 0);
    bus.out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("fullpp_drain", int'(bus.out_data), i);
      step();
    end
    bus.out_ready = 1'b0;

    // Wrap with backpressure: capture, stall one cycle, then pop
    for (int v = 1; v <= 10; v++) begin
      bus.mlu_result = DATA_W'(v);
      bus.mlu_ready  = 1'b1;
      step();
      bus.mlu_ready = 1'b0;
      check("wrap_head", int'(bus.out_data), v);
      step();
      check("wrap_stall_head", int'(bus.out_data), v);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
    check("wrap_count", int'(bus.count), 0);
    check("wrap_overflow", int'(bus.overflow), 0);

    // Clear beats a same-cycle capture and pop
    for (int i = 11; i <= 15; i++) pulse(DATA_W'(i));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("clr_pre_count", int'(bus.count), 3);
    check("clr_pre_ovf", int'(bus.overflow), 1);
    bus.mlu_result = 6'd42;
    bus.mlu_ready  = 1'b1;
    bus.out_ready  = 1'b1;
    bus.clear      = 1'b1;
    step();
    bus.clear     = 1'b0;
    bus.mlu_ready = 1'b0;
    bus.out_ready = 1'b0;
    check("clr_count", int'(bus.count), 0);
    check("clr_valid", int'(bus.out_valid), 0);
    check("clr_ovf", int'(bus.overflow), 0);
    step();
    check("clr_not_stored", int'(bus.count), 0);

    // Random traffic, checked by the monitor against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) bus.mlu_ready = ~bus.mlu_ready;
      bus.mlu_result = DATA_W'($urandom);
      bus.out_ready  = ($urandom_range(0, 2) == 0);
      bus.clear      = ($urandom_range(0, 60) == 0);
      step();
    end
    bus.mlu_ready = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    check("final_count", int'(bus.count), 0);
    bus.out_ready = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
